fp_stream_unpacker: RTL and testbench
=====================================

Name: fp_stream_unpacker

Overview:
- Parametrised successor to the double-precision stream-to-FP front end of the decoder top level.
- Accepts a packed DATA_W-bit encoded word stream (tdata/tlast, valid/ready) and emits one unpacked floating-point value (sign/expo/frac) per handshake.
- Supports LANES = DATA_W/(1+EXPO_W+FRAC_W) values per word, a short final word, and tlast propagation.
- Sits between the AXI-style input channel and the FP consumer channel, with zero-bubble back-to-back operation.

Parameters:
- DATA_W, 64, input word width in bits.
- EXPO_W, 11, exponent field width.
- FRAC_W, 52, fraction field width.
- FP_W, 1+EXPO_W+FRAC_W (derived, localparam), packed FP width.
- LANES, DATA_W/FP_W (derived, localparam), FP values per word; elaboration error if 0.
- NUM_W, max(1,$clog2(LANES)) (derived), width of lane-count field.

Ports:
- clk_scclang_global_0  in  1  clock, all logic on rising edge.
- reset_scclang_global_5  in  1  synchronous, active-high reset.
- c_in_data_tdata  in  DATA_W  packed word; lane k occupies bits [k*FP_W +: FP_W], {sign, expo, frac} MSB first.
- c_in_data_tnum  in  NUM_W  number of valid lanes minus 1 (full word = LANES-1).
- c_in_data_tlast  in  1  last word of packet.
- c_in_valid  in  1  input word valid.
- c_in_ready  out  1  input word accepted when valid&&ready.
- c_out_data_frac  out  FRAC_W  fraction of current lane.
- c_out_data_expo  out  EXPO_W  exponent of current lane.
- c_out_data_sign  out  1  sign of current lane.
- c_out_data_last  out  1  final value of packet.
- c_out_valid  out  1  output value valid.
- c_out_ready  in  1  consumer ready.

Behaviour:
- Reset (synchronous, active-high, the only reset): full_q=0, lane_q=0, nlanes_q=0, last_q=0, word_q=0.
- Reset output values: c_out_valid=0, c_out_data_*=0, c_in_ready=1 in the first cycle after reset deasserts. While reset is high, c_in_ready=0.
- State: EMPTY (full_q=0) and HOLD (full_q=1).
- c_out_valid = full_q. Output fields are sliced from word_q at lane_q (registered source, no combinational path from c_in_* to c_out_*).
- out_fire = c_out_valid && c_out_ready. final = (lane_q == nlanes_q).
- c_in_ready = !full_q || (out_fire && final). This is combinational from c_out_ready and enables a zero-bubble handoff.
- c_out_data_last = last_q && final.
- in_fire loads word_q, sets nlanes_q = min(tnum, LANES-1) (clamp only when LANES is not a power of 2), last_q = tlast, lane_q = 0, full_q = 1.
- out_fire && !final: lane_q += 1.
- out_fire && final && !in_fire: full_q = 0.
- out_fire && final && in_fire: new word is loaded; full_q stays 1.
- Latency: input accept to c_out_valid is 1 cycle.
- Throughput: 1 value per cycle under continuous ready. Each word occupies nlanes_q+1 cycles.
- Backpressure: while c_out_valid && !c_out_ready, all output fields and c_out_valid hold stable.
- Unused upper bits of tdata (DATA_W - LANES*FP_W) are ignored.
- Reset mid-word: the partial word is discarded and no further lanes are emitted.

Optional Feature:
- Macro: FP_STREAM_UNPACKER_STATS_EN.
- Defined: adds two outputs.
  - stat_values (32 bits): counts out_fire.
  - stat_packets (32 bits): counts out_fire && c_out_data_last.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package fp_stream_pkg: default widths (DP_EXPO_W=11, DP_FRAC_W=52, SP_EXPO_W=8, SP_FRAC_W=23) and a typedef fp_fields_t template built from parameters.
- Helper function lanes_f(data_w, expo_w, frac_w) lives in the package.
- No sub-module; the lane slice is a single indexed part-select.

Test Plan:
- Double, 1 lane: word 64'h3FF0_0000_0000_0000, tnum=0, tlast=1 → one output: sign=0, expo=11'h3FF, frac=0, last=1, valid on the next cycle.
- Single, DATA_W=64/EXPO_W=8/FRAC_W=23, 2 lanes: word {32'hC0000000, 32'h3F800000}, tnum=1 → lane0 sign=0/expo=8'h7F, then lane1 sign=1/expo=8'h80; last only on lane1 if tlast=1.
- Short final word, single precision: tnum=0, tlast=1 → only lane0 emitted, with last=1; the upper lane is never presented.
- Back-to-back with c_out_ready=1: 4 full double words → 4 outputs in 4 consecutive cycles, and c_in_ready stays high throughout.
- Backpressure: c_out_ready low for 5 cycles mid-word → outputs stable, c_in_ready=0, lane_q unchanged; then resumes in order.
- Synchronous reset asserted with lane1 pending → c_out_valid=0 the next cycle; lane1 is never emitted. With STATS_EN: 3 packets of 2 values each → stat_values=6, stat_packets=3.

Source files
------------

// File: rtl/fp_stream_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Package : fp_stream_pkg
// Brief   : Default FP field widths, lane-count helper and shared types.
// Rev     : 1.0 - initial release
// ============================================================================
package fp_stream_pkg;

  localparam int DP_EXPO_W = 11;
  localparam int DP_FRAC_W = 52;
  localparam int SP_EXPO_W = 8;
  localparam int SP_FRAC_W = 23;

  // Template layout at the default (double) widths; modules re-declare the
  // same shape from their own parameters.
  typedef struct packed {
    logic                 sign;
    logic [DP_EXPO_W-1:0] expo;
    logic [DP_FRAC_W-1:0] frac;
  } fp_fields_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic int lanes_f(input int data_w, input int expo_w, input int frac_w);
    return data_w / (1 + expo_w + frac_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_stream_unpacker_if.sv
`default_nettype none
// ============================================================================
// Interface : fp_stream_unpacker_if
// Brief     : Packed-word input channel and unpacked FP output channel.
// Rev       : 1.0 - initial release
// ============================================================================
interface fp_stream_unpacker_if
  import fp_stream_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int EXPO_W = DP_EXPO_W,
  parameter int FRAC_W = DP_FRAC_W
);

  localparam int LANES = lanes_f(DATA_W, EXPO_W, FRAC_W);
  localparam int NUM_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DATA_W-1:0] c_in_data_tdata;
  logic [NUM_W-1:0]  c_in_data_tnum;
  logic              c_in_data_tlast;
  logic              c_in_valid;
  logic              c_in_ready;

  logic [FRAC_W-1:0] c_out_data_frac;
  logic [EXPO_W-1:0] c_out_data_expo;
  logic              c_out_data_sign;
  logic              c_out_data_last;
  logic              c_out_valid;
  logic              c_out_ready;

  // Unpacker side
  modport slave (
    input  c_in_data_tdata, c_in_data_tnum, c_in_data_tlast, c_in_valid,
    output c_in_ready,
    output c_out_data_frac, c_out_data_expo, c_out_data_sign, c_out_data_last,
    output c_out_valid,
    input  c_out_ready
  );

  // Environment side: word producer and FP consumer
  modport master (
    output c_in_data_tdata, c_in_data_tnum, c_in_data_tlast, c_in_valid,
    input  c_in_ready,
    input  c_out_data_frac, c_out_data_expo, c_out_data_sign, c_out_data_last,
    input  c_out_valid,
    output c_out_ready
  );

endinterface
`default_nettype wire

// File: rtl/fp_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module : fp_stream_unpacker
// Brief  : Splits packed words into one {sign,expo,frac} value per handshake.
//          Optional counters enabled by FP_STREAM_UNPACKER_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module fp_stream_unpacker
  import fp_stream_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int EXPO_W = DP_EXPO_W,
  parameter int FRAC_W = DP_FRAC_W
) (
  input  wire logic           clk_scclang_global_0,
  input  wire logic           reset_scclang_global_5,
  fp_stream_unpacker_if.slave bus
`ifdef FP_STREAM_UNPACKER_STATS_EN
  ,
  output      logic [31:0]    stat_values,
  output      logic [31:0]    stat_packets
`endif
);

  localparam int FP_W  = 1 + EXPO_W + FRAC_W;
  localparam int LANES = lanes_f(DATA_W, EXPO_W, FRAC_W);
  localparam int NUM_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [NUM_W-1:0] LAST_LANE = NUM_W'(LANES - 1);

  generate
    if (LANES < 1) begin : g_lanes_invalid
      $error("fp_stream_unpacker: DATA_W too narrow for one FP value");
    end
  endgenerate

  typedef struct packed {
    logic              sign;
    logic [EXPO_W-1:0] expo;
    logic [FRAC_W-1:0] frac;
  } lane_t;

  state_t            full_q, full_d;
  logic [NUM_W-1:0]  lane_q, lane_d;
  logic [NUM_W-1:0]  nlanes_q, nlanes_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] word_q, word_d;

  logic              out_fire;
  logic              in_fire;
  logic              is_final;
  logic              in_ready;
  logic [IDX_W-1:0]  lane_base;
  lane_t             lane_fields;

  assign lane_base   = IDX_W'(32'(lane_q) * 32'(FP_W));
  assign lane_fields = word_q[lane_base +: FP_W];

  // Ready looks through to the consumer so the final lane and the next word
  // can trade places on the same edge.
  always_comb begin
    out_fire = (full_q == ST_HOLD) && bus.c_out_ready;
    is_final = (lane_q == nlanes_q);
    in_ready = !reset_scclang_global_5 &&
               ((full_q == ST_EMPTY) || (out_fire && is_final));
    in_fire  = bus.c_in_valid && in_ready;
  end

  always_comb begin
    full_d   = full_q;
    lane_d   = lane_q;
    nlanes_d = nlanes_q;
    last_d   = last_q;
    word_d   = word_q;
    if (in_fire) begin
      word_d   = bus.c_in_data_tdata;
      nlanes_d = (bus.c_in_data_tnum > LAST_LANE) ? LAST_LANE : bus.c_in_data_tnum;
      last_d   = bus.c_in_data_tlast;
      lane_d   = '0;
      full_d   = ST_HOLD;
    end else if (out_fire) begin
      if (is_final) begin
        full_d = ST_EMPTY;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_scclang_global_0) begin
    if (reset_scclang_global_5) begin
      full_q   <= ST_EMPTY;
      lane_q   <= '0;
      nlanes_q <= '0;
      last_q   <= 1'b0;
      word_q   <= '0;
    end else begin
      full_q   <= full_d;
      lane_q   <= lane_d;
      nlanes_q <= nlanes_d;
      last_q   <= last_d;
      word_q   <= word_d;
    end
  end

  assign bus.c_in_ready      = in_ready;
  assign bus.c_out_valid     = (full_q == ST_HOLD);
  assign bus.c_out_data_sign = lane_fields.sign;
  assign bus.c_out_data_expo = lane_fields.expo;
  assign bus.c_out_data_frac = lane_fields.frac;
  assign bus.c_out_data_last = last_q && is_final;

`ifdef FP_STREAM_UNPACKER_STATS_EN
  logic [31:0] stat_values_q, stat_values_d;
  logic [31:0] stat_packets_q, stat_packets_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stat_values_d  = stat_values_q;
    stat_packets_d = stat_packets_q;
    if (out_fire && (stat_values_q != '1)) begin
      stat_values_d = stat_values_q + 32'd1;
    end
    if (out_fire && last_q && is_final && (stat_packets_q != '1)) begin
      stat_packets_d = stat_packets_q + 32'd1;
    end
  end

  always_ff @(posedge clk_scclang_global_0) begin
    if (reset_scclang_global_5) begin
      stat_values_q  <= '0;
      stat_packets_q <= '0;
    end else begin
      stat_values_q  <= stat_values_d;
      stat_packets_q <= stat_packets_d;
    end
  end

  assign stat_values  = stat_values_q;
  assign stat_packets = stat_packets_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module : tb_fp_stream_unpacker
// Brief  : Double (1 lane) and single (2 lane) instances against a queue model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fp_stream_unpacker;

  typedef struct {
    logic        sign;
    logic [63:0] expo;
    logic [63:0] frac;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: double precision, index 1: single precision (both 64-bit words)
  logic        in_valid  [2];
  logic [63:0] in_data   [2];
  logic        in_tnum   [2];
  logic        in_tlast  [2];
  logic        out_ready [2];
  logic        o_in_ready[2];
  logic        o_valid   [2];
  logic        o_sign    [2];
  logic [63:0] o_expo    [2];
  logic [63:0] o_frac    [2];
  logic        o_last    [2];

  fp_stream_unpacker_if #(.DATA_W(64), .EXPO_W(11), .FRAC_W(52)) if_d ();
  fp_stream_unpacker_if #(.DATA_W(64), .EXPO_W(8),  .FRAC_W(23)) if_s ();

  assign if_d.c_in_valid      = in_valid[0];
  assign if_d.c_in_data_tdata = in_data[0];
  assign if_d.c_in_data_tnum  = in_tnum[0];
  assign if_d.c_in_data_tlast = in_tlast[0];
  assign if_d.c_out_ready     = out_ready[0];
  assign o_in_ready[0] = if_d.c_in_ready;
  assign o_valid[0]    = if_d.c_out_valid;
  assign o_sign[0]     = if_d.c_out_data_sign;
  assign o_expo[0]     = 64'(if_d.c_out_data_expo);
  assign o_frac[0]     = 64'(if_d.c_out_data_frac);
  assign o_last[0]     = if_d.c_out_data_last;

  assign if_s.c_in_valid      = in_valid[1];
  assign if_s.c_in_data_tdata = in_data[1];
  assign if_s.c_in_data_tnum  = in_tnum[1];
  assign if_s.c_in_data_tlast = in_tlast[1];
  assign if_s.c_out_ready     = out_ready[1];
  assign o_in_ready[1] = if_s.c_in_ready;
  assign o_valid[1]    = if_s.c_out_valid;
  assign o_sign[1]     = if_s.c_out_data_sign;
  assign o_expo[1]     = 64'(if_s.c_out_data_expo);
  assign o_frac[1]     = 64'(if_s.c_out_data_frac);
  assign o_last[1]     = if_s.c_out_data_last;

`ifdef FP_STREAM_UNPACKER_STATS_EN
  logic [31:0] st_vals[2];
  logic [31:0] st_pkts[2];
`endif

  fp_stream_unpacker #(.DATA_W(64), .EXPO_W(11), .FRAC_W(52)) u_dp (
    .clk_scclang_global_0   (clk),
    .reset_scclang_global_5 (rst),
    .bus                    (if_d.slave)
`ifdef FP_STREAM_UNPACKER_STATS_EN
    ,
    .stat_values            (st_vals[0]),
    .stat_packets           (st_pkts[0])
`endif
  );

  fp_stream_unpacker #(.DATA_W(64), .EXPO_W(8), .FRAC_W(23)) u_sp (
    .clk_scclang_global_0   (clk),
    .reset_scclang_global_5 (rst),
    .bus                    (if_s.slave)
`ifdef FP_STREAM_UNPACKER_STATS_EN
    ,
    .stat_values            (st_vals[1]),
    .stat_packets           (st_pkts[1])
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ew(input int d); return (d == 0) ? 11 : 8;  endfunction
  function automatic int fw(input int d); return (d == 0) ? 52 : 23; endfunction
  function automatic int ln(input int d); return (d == 0) ? 1  : 2;  endfunction

  function automatic exp_t decode(input logic [63:0] data, input int k, input int d);
    exp_t e;
    int   base;
    base   = k * (1 + ew(d) + fw(d));
    e.frac = (data >> base) & ((64'd1 << fw(d)) - 64'd1);
    e.expo = (data >> (base + fw(d))) & ((64'd1 << ew(d)) - 64'd1);
    e.sign = data[base + ew(d) + fw(d)];
    e.last = 1'b0;
    return e;
  endfunction

  exp_t        mq[2][$];
  int unsigned m_vals[2];
  int unsigned m_pkts[2];

  task automatic push_word(input int d, input logic [63:0] data, input logic tnum, input logic tlast);
    int   n;
    exp_t e;
    n = (int'(tnum) > ln(d) - 1) ? ln(d) - 1 : int'(tnum);
    for (int k = 0; k <= n; k++) begin
      e      = decode(data, k, d);
      e.last = tlast && (k == n);
      mq[d].push_back(e);
    end
  endtask

  // ---------------- compare process ----------------
  logic        rec_rst = 1'b0;
  logic        rec_in  [2] = '{1'b0, 1'b0};
  logic        rec_out [2] = '{1'b0, 1'b0};
  logic [63:0] rec_data[2];
  logic        rec_tnum[2];
  logic        rec_last[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      // Apply what happened at the previous rising edge
      if (rec_rst) begin
        mq[d].delete();
        m_vals[d] = 0;
        m_pkts[d] = 0;
      end else begin
        if (rec_out[d] && mq[d].size() > 0) begin
          m_vals[d]++;
          if (mq[d][0].last) m_pkts[d]++;
          void'(mq[d].pop_front());
        end
        if (rec_in[d]) push_word(d, rec_data[d], rec_tnum[d], rec_last[d]);
      end

      chk("out_valid", d, 64'(o_valid[d]), 64'(mq[d].size() > 0));
      chk("in_ready", d, 64'(o_in_ready[d]),
          64'(!rst && (mq[d].size() == 0 || (mq[d].size() == 1 && out_ready[d]))));
      if (o_valid[d] && mq[d].size() > 0) begin
        chk("sign", d, 64'(o_sign[d]), 64'(mq[d][0].sign));
        chk("expo", d, o_expo[d], mq[d][0].expo);
        chk("frac", d, o_frac[d], mq[d][0].frac);
        chk("last", d, 64'(o_last[d]), 64'(mq[d][0].last));
      end
      if (rec_rst) begin
        chk("rst_fields", d, {o_expo[d][31:0], o_frac[d][30:0], o_sign[d]}, 64'd0);
        chk("rst_last", d, 64'(o_last[d]), 64'd0);
      end
`ifdef FP_STREAM_UNPACKER_STATS_EN
      chk("stat_values", d, 64'(st_vals[d]), 64'(m_vals[d]));
      chk("stat_packets", d, 64'(st_pkts[d]), 64'(m_pkts[d]));
`endif

      rec_in[d]   = in_valid[d] && o_in_ready[d];
      rec_out[d]  = o_valid[d] && out_ready[d];
      rec_data[d] = in_data[d];
      rec_tnum[d] = in_tnum[d];
      rec_last[d] = in_tlast[d];
    end
    rec_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [63:0] data, input logic tnum, input logic tlast);
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_tnum[d]  = tnum;
    in_tlast[d] = tlast;
  endtask

  exp_t pin;

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_tnum[d] = 1'b0;
      in_tlast[d] = 1'b0; out_ready[d] = 1'b1;
      m_vals[d] = 0; m_pkts[d] = 0;
    end

    // Model pins against hand-decoded IEEE values
    pin = decode(64'hC0000000_3F800000, 0, 1);
    chk("pin_sp_l0_expo", 1, pin.expo, 64'h7F);
    pin = decode(64'hC0000000_3F800000, 1, 1);
    chk("pin_sp_l1_sign", 1, 64'(pin.sign), 64'd1);
    chk("pin_sp_l1_expo", 1, pin.expo, 64'h80);
    pin = decode(64'h3FF0_0000_0000_0000, 0, 0);
    chk("pin_dp_expo", 0, pin.expo, 64'h3FF);

    repeat (3) step();
    rst = 1'b0;
    step();

    // Double, one lane
    send(0, 64'h3FF0_0000_0000_0000, 1'b0, 1'b1);
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("dp_valid", 0, 64'(o_valid[0]), 64'd1);
    chk("dp_sign",  0, 64'(o_sign[0]),  64'd0);
    chk("dp_expo",  0, o_expo[0], 64'h3FF);
    chk("dp_frac",  0, o_frac[0], 64'd0);
    chk("dp_last",  0, 64'(o_last[0]), 64'd1);
    step();

    // Single, two lanes
    send(1, 64'hC0000000_3F800000, 1'b1, 1'b1);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("sp_l0_sign", 1, 64'(o_sign[1]), 64'd0);
    chk("sp_l0_expo", 1, o_expo[1], 64'h7F);
    chk("sp_l0_last", 1, 64'(o_last[1]), 64'd0);
    step();
    @(negedge clk);
    chk("sp_l1_sign", 1, 64'(o_sign[1]), 64'd1);
    chk("sp_l1_expo", 1, o_expo[1], 64'h80);
    chk("sp_l1_last", 1, 64'(o_last[1]), 64'd1);
    step();

    // Short final word: only lane 0 presented
    send(1, 64'h40400000_3F800000, 1'b0, 1'b1);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    chk("short_expo", 1, o_expo[1], 64'h7F);
    chk("short_last", 1, 64'(o_last[1]), 64'd1);
    step();
    @(negedge clk);
    chk("short_done", 1, 64'(o_valid[1]), 64'd0);
    step();

    // Back-to-back double words
    for (int i = 0; i < 4; i++) begin
      send(0, 64'h4000_0000_0000_0000 + 64'(i), 1'b0, 1'(i == 3));
      @(negedge clk);
      chk("b2b_in_ready", 0, 64'(o_in_ready[0]), 64'd1);
      if (i > 0) chk("b2b_out_valid", 0, 64'(o_valid[0]), 64'd1);
      step();
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_tail_frac", 0, o_frac[0], 64'd3);
    step();

    // Backpressure mid-word with the next word waiting
    send(1, 64'hC1200000_40A00000, 1'b1, 1'b0);
    step();
    send(1, 64'h41000000_BF800000, 1'b1, 1'b1);
    @(negedge clk);
    chk("bp_in_ready_l0", 1, 64'(o_in_ready[1]), 64'd0);
    step();
    out_ready[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 1, 64'(o_valid[1]), 64'd1);
      chk("bp_in_ready", 1, 64'(o_in_ready[1]), 64'd0);
      chk("bp_sign", 1, 64'(o_sign[1]), 64'd1);
      chk("bp_expo", 1, o_expo[1], 64'h82);
      chk("bp_frac", 1, o_frac[1], 64'h200000);
      step();
    end
    out_ready[1] = 1'b1;
    step();
    in_valid[1] = 1'b0;
    repeat (3) step();

    // Reset with lane 1 still pending
    send(1, 64'h40000000_3F800000, 1'b1, 1'b1);
    step();
    in_valid[1] = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 1, 64'(o_in_ready[1]), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 1, 64'(o_valid[1]), 64'd0);
    chk("rst_in_ready_after", 1, 64'(o_in_ready[1]), 64'd1);
    step();

    // Three two-value packets on the single-precision lane pair
    for (int p = 0; p < 3; p++) begin
      send(1, {$urandom, $urandom}, 1'b1, 1'b1);
      step();
      in_valid[1] = 1'b0;
      step();
    end
    repeat (2) step();

    // Randomised traffic on both instances
    for (int c = 0; c < 800; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        in_data[d]   = {$urandom, $urandom};
        in_tnum[d]   = 1'($urandom_range(0, 1));
        in_tlast[d]  = 1'($urandom_range(0, 1));
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      rst = (c == 400);
      step();
    end
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
